mem_ctrl: RTL and testbench

Memory controller sitting between the IF/MEM stages and the byte-wide RAM/IO bus. It arbitrates instruction fetches against MEM-stage loads/stores and serialises each request into 1–4 single-byte RAM cycles. It returns assembled little-endian words with a one-cycle `finished` pulse, and exports busy flags that MEM uses to gate its requests.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared configuration for the byte-serial memory controller: state and owner
// encodings, IO region selector, data-length constants and a byte-lane helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [1:0]  IO_SEL_DEFAULT = 2'b11;

    localparam logic [2:0]  LEN_BYTE = 3'd1;
    localparam logic [2:0]  LEN_HALF = 3'd2;
    localparam logic [2:0]  LEN_WORD = 3'd4;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [2:0] idx);
        return word[{idx[1:0], 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM bus signals of the memory controller; the slave
// modport is the controller's view, the master modport the requester/RAM side.
interface mem_ctrl_if;

    logic        if_enable_i;
    logic [31:0] if_addr_i;
    logic        if_finished_o;
    logic [31:0] if_inst_o;
    logic        mem_enable_i;
    logic        mem_rw_sel_i;
    logic [31:0] mem_addr_i;
    logic [2:0]  mem_data_len_i;
    logic [31:0] mem_data_i;
    logic        mem_finished_o;
    logic [31:0] mem_data_o;
    logic        if_busy_o;
    logic        mem_busy_o;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  if_enable_i, if_addr_i, mem_enable_i, mem_rw_sel_i, mem_addr_i,
               mem_data_len_i, mem_data_i, mem_din, io_buffer_full,
        output if_finished_o, if_inst_o, mem_finished_o, mem_data_o,
               if_busy_o, mem_busy_o, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_enable_i, if_addr_i, mem_enable_i, mem_rw_sel_i, mem_addr_i,
               mem_data_len_i, mem_data_i, mem_din, io_buffer_full,
        input  if_finished_o, if_inst_o, mem_finished_o, mem_data_o,
               if_busy_o, mem_busy_o, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches against MEM loads/stores and serialises each request
// into 1-4 byte cycles on the RAM/IO bus, assembling little-endian words.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);

    state_t      r_state;
    owner_t      r_owner;
    logic [31:0] r_addr;
    logic [2:0]  r_n;
    logic [31:0] r_data;
    logic [2:0]  r_k;
    logic [31:0] r_buf;

    state_t      w_next_state;
    logic [31:0] w_mem_a;
    logic        w_mem_wr;
    logic [7:0]  w_mem_dout;
    logic        w_io_stall;
    logic [2:0]  w_cap_idx;
    logic        w_done;
    logic        w_busy;

    // State register; rdy low freezes the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_next_state;
        end else begin
            r_state <= r_state;
        end
    end

    // Next-state and bus drive decode.
    always_comb begin
        w_next_state = r_state;
        w_mem_a      = ZERO_WORD;
        w_mem_wr     = DISABLE;
        w_mem_dout   = 8'h00;
        w_io_stall   = (r_addr[17:16] == IO_SEL) && bus.io_buffer_full;
        w_cap_idx    = r_k - 3'd1;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_enable_i) begin
                    w_next_state = bus.mem_rw_sel_i ? ST_WRITE : ST_READ;
                end else if (bus.if_enable_i) begin
                    w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                // Address phase runs one cycle ahead of capture, so r_k reaches r_n
                // in the cycle the last byte arrives.
                if (r_k < r_n) begin
                    w_mem_a = r_addr + {29'd0, r_k};
                end else begin
                    w_mem_a = ZERO_WORD;
                end
                if (r_k == r_n) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_WRITE: begin
                w_mem_a    = r_addr + {29'd0, r_k};
                w_mem_dout = get_byte(r_data, r_k);
                if (w_io_stall) begin
                    w_mem_wr     = DISABLE;
                    w_next_state = ST_WRITE;
                end else if (r_k == (r_n - 3'd1)) begin
                    w_mem_wr     = ENABLE;
                    w_next_state = ST_DONE;
                end else begin
                    w_mem_wr     = ENABLE;
                    w_next_state = ST_WRITE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, byte counter and read-assembly buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_IF;
            r_addr  <= ZERO_WORD;
            r_n     <= 3'd0;
            r_data  <= ZERO_WORD;
            r_k     <= 3'd0;
            r_buf   <= ZERO_WORD;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_enable_i) begin
                        r_owner <= OWN_MEM;
                        r_addr  <= bus.mem_addr_i;
                        r_n     <= bus.mem_rw_sel_i ? (bus.mem_data_len_i + 3'd1) : bus.mem_data_len_i;
                        r_data  <= bus.mem_data_i;
                        r_k     <= 3'd0;
                        r_buf   <= ZERO_WORD;
                    end else if (bus.if_enable_i) begin
                        r_owner <= OWN_IF;
                        r_addr  <= bus.if_addr_i;
                        r_n     <= LEN_WORD;
                        r_data  <= ZERO_WORD;
                        r_k     <= 3'd0;
                        r_buf   <= ZERO_WORD;
                    end else begin
                        r_k     <= 3'd0;
                    end
                end
                ST_READ: begin
                    if (r_k != 3'd0) begin
                        r_buf[{w_cap_idx[1:0], 3'b000} +: 8] <= bus.mem_din;
                    end else begin
                        r_buf <= r_buf;
                    end
                    if (r_k != r_n) begin
                        r_k <= r_k + 3'd1;
                    end else begin
                        r_k <= r_k;
                    end
                end
                ST_WRITE: begin
                    if (!w_io_stall) begin
                        r_k <= r_k + 3'd1;
                    end else begin
                        r_k <= r_k;
                    end
                end
                ST_DONE: begin
                    r_k <= 3'd0;
                end
                default: begin
                    r_k <= 3'd0;
                end
            endcase
        end else begin
            r_k <= r_k;
        end
    end

    assign w_done = (r_state == ST_DONE);
    assign w_busy = (r_state != ST_IDLE);

    assign bus.mem_a          = w_mem_a;
    assign bus.mem_wr         = w_mem_wr & rdy;
    assign bus.mem_dout       = w_mem_dout;
    assign bus.if_finished_o  = w_done && (r_owner == OWN_IF);
    assign bus.mem_finished_o = w_done && (r_owner == OWN_MEM);
    assign bus.if_inst_o      = (w_done && (r_owner == OWN_IF))  ? r_buf : ZERO_WORD;
    assign bus.mem_data_o     = (w_done && (r_owner == OWN_MEM)) ? r_buf : ZERO_WORD;
    assign bus.if_busy_o      = w_busy && (r_owner == OWN_IF);
    assign bus.mem_busy_o     = w_busy && (r_owner == OWN_MEM);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide read-only RAM model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [7:0] ram [0:65535];

    mem_ctrl_if bus();

    mem_ctrl #(.IO_SEL(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Read data returns one cycle after its address.
    always @(posedge clk) bus.mem_din <= ram[bus.mem_a[15:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.if_enable_i  = 1'b0;
        bus.mem_enable_i = 1'b0;
    endtask

    task automatic run_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_inst);
        bus.if_addr_i   = addr;
        bus.if_enable_i = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk($sformatf("%s_busy%0d", tag, j), 32'(bus.if_busy_o), 32'd1);
            chk($sformatf("%s_fin%0d", tag, j), 32'(bus.if_finished_o), 32'(j == 6));
            if (j <= 4) chk($sformatf("%s_a%0d", tag, j), bus.mem_a, addr + 32'(j - 1));
            if (j == 6) begin
                chk($sformatf("%s_inst", tag), bus.if_inst_o, exp_inst);
                bus.if_enable_i = 1'b0;
            end
        end
        step();
        chk($sformatf("%s_idle", tag), 32'(bus.if_busy_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13;
        ram[16'h1004] = 8'h78; ram[16'h1005] = 8'h56;
        ram[16'h1006] = 8'h34; ram[16'h1007] = 8'h12;
        ram[16'h2003] = 8'h80; ram[16'h2004] = 8'h7F;
        ram[16'h2010] = 8'h11; ram[16'h2011] = 8'h22;
        ram[16'h2012] = 8'h33; ram[16'h2013] = 8'h44;

        rst = 1'b1;
        rdy = 1'b1;
        bus.if_enable_i    = 1'b0;
        bus.if_addr_i      = 32'h0;
        bus.mem_enable_i   = 1'b0;
        bus.mem_rw_sel_i   = 1'b0;
        bus.mem_addr_i     = 32'h0;
        bus.mem_data_len_i = 3'd0;
        bus.mem_data_i     = 32'h0;
        bus.io_buffer_full = 1'b0;
        #1;
        chk("rst_busy", {30'd0, bus.if_busy_o, bus.mem_busy_o}, 32'd0);
        chk("rst_fin", {30'd0, bus.if_finished_o, bus.mem_finished_o}, 32'd0);
        chk("rst_a", bus.mem_a, 32'd0);
        chk("rst_wr", 32'(bus.mem_wr), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // IF fetch, then a fetch with all four byte lanes distinct.
        run_fetch("if1", 32'h0000_1000, 32'h0000_0013);
        run_fetch("if2", 32'h0000_1004, 32'h1234_5678);

        // LB: finished in T+3, upper bytes cleared from previous contents.
        bus.mem_addr_i = 32'h2003; bus.mem_rw_sel_i = 1'b0; bus.mem_data_len_i = LEN_BYTE;
        bus.mem_enable_i = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step();
            chk($sformatf("lb_busy%0d", j), 32'(bus.mem_busy_o), 32'd1);
            chk($sformatf("lb_fin%0d", j), 32'(bus.mem_finished_o), 32'(j == 3));
            if (j == 1) chk("lb_wr", 32'(bus.mem_wr), 32'd0);
            if (j == 3) begin
                chk("lb_data", bus.mem_data_o, 32'h0000_0080);
                drop_all();
            end
        end
        step();
        chk("lb_idle", 32'(bus.mem_busy_o), 32'd0);

        // LH at 0x2003: two bytes 0x80, 0x7F.
        bus.mem_addr_i = 32'h2003; bus.mem_data_len_i = LEN_HALF; bus.mem_enable_i = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            chk($sformatf("lh_fin%0d", j), 32'(bus.mem_finished_o), 32'(j == 4));
            if (j == 4) begin
                chk("lh_data", bus.mem_data_o, 32'h0000_7F80);
                drop_all();
            end
        end
        step();

        // SW 0xDEADBEEF at 0x2000: EF,BE,AD,DE in T+1..T+4, finished T+5.
        bus.mem_addr_i = 32'h2000; bus.mem_rw_sel_i = 1'b1; bus.mem_data_len_i = 3'd3;
        bus.mem_data_i = 32'hDEAD_BEEF; bus.mem_enable_i = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step();
            chk($sformatf("sw_wr%0d", j), 32'(bus.mem_wr), 32'(j <= 4));
            chk($sformatf("sw_fin%0d", j), 32'(bus.mem_finished_o), 32'(j == 5));
            if (j <= 4) begin
                logic [31:0] exp_word;
                exp_word = 32'hDEAD_BEEF;
                chk($sformatf("sw_a%0d", j), bus.mem_a, 32'h2000 + 32'(j - 1));
                chk($sformatf("sw_d%0d", j), 32'(bus.mem_dout), 32'(exp_word[8*(j-1) +: 8]));
            end
            if (j == 5) drop_all();
        end
        step();
        chk("sw_idle_a", bus.mem_a, 32'd0);

        // SH with rdy low for one cycle: write delayed, AA then BB.
        bus.mem_addr_i = 32'h2100; bus.mem_data_len_i = 3'd1; bus.mem_data_i = 32'h0000_BBAA;
        bus.mem_enable_i = 1'b1;
        step();
        rdy = 1'b0;
        #1;
        chk("sh_frz_wr", 32'(bus.mem_wr), 32'd0);
        step();
        rdy = 1'b1;
        #1;
        chk("sh_wr0", 32'(bus.mem_wr), 32'd1);
        chk("sh_a0", bus.mem_a, 32'h2100);
        chk("sh_d0", 32'(bus.mem_dout), 32'h0000_00AA);
        step();
        chk("sh_a1", bus.mem_a, 32'h2101);
        chk("sh_d1", 32'(bus.mem_dout), 32'h0000_00BB);
        step();
        chk("sh_fin", 32'(bus.mem_finished_o), 32'd1);
        drop_all();
        step();

        // IF and MEM LW together: MEM first, IF accepted the cycle after DONE.
        bus.if_addr_i = 32'h1004; bus.if_enable_i = 1'b1;
        bus.mem_addr_i = 32'h2010; bus.mem_rw_sel_i = 1'b0; bus.mem_data_len_i = LEN_WORD;
        bus.mem_enable_i = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            step();
            chk($sformatf("arb_ifb%0d", j), 32'(bus.if_busy_o), 32'(j >= 8));
            chk($sformatf("arb_mb%0d", j), 32'(bus.mem_busy_o), 32'(j <= 6));
            chk($sformatf("arb_mf%0d", j), 32'(bus.mem_finished_o), 32'(j == 6));
            chk($sformatf("arb_if%0d", j), 32'(bus.if_finished_o), 32'(j == 13));
            if (j == 6) begin
                chk("arb_mdata", bus.mem_data_o, 32'h4433_2211);
                bus.mem_enable_i = 1'b0;
            end
            if (j == 13) begin
                chk("arb_inst", bus.if_inst_o, 32'h1234_5678);
                chk("arb_mdata0", bus.mem_data_o, 32'd0);
                drop_all();
            end
        end
        step();

        // SB to IO region with io_buffer_full high for three cycles.
        bus.mem_addr_i = 32'h0003_0000; bus.mem_rw_sel_i = 1'b1; bus.mem_data_len_i = 3'd0;
        bus.mem_data_i = 32'h0000_00A5; bus.mem_enable_i = 1'b1; bus.io_buffer_full = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step();
            if (j == 4) begin
                bus.io_buffer_full = 1'b0;
                #1;
            end
            chk($sformatf("io_wr%0d", j), 32'(bus.mem_wr), 32'(j == 4));
            chk($sformatf("io_fin%0d", j), 32'(bus.mem_finished_o), 32'(j == 5));
            if (j <= 4) chk($sformatf("io_a%0d", j), bus.mem_a, 32'h0003_0000);
            if (j == 4) chk("io_d", 32'(bus.mem_dout), 32'h0000_00A5);
            if (j == 5) drop_all();
        end
        step();

        // Reset during byte 2 of a fetch, then re-issue.
        bus.if_addr_i = 32'h1004; bus.if_enable_i = 1'b1;
        step();
        step();
        step();
        chk("rf_pre_a", bus.mem_a, 32'h1006);
        rst = 1'b1;
        #1;
        chk("rf_busy", 32'(bus.if_busy_o), 32'd0);
        chk("rf_a", bus.mem_a, 32'd0);
        chk("rf_inst", bus.if_inst_o, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rf_idle", 32'(bus.if_busy_o), 32'd0);
        run_fetch("rf", 32'h0000_1004, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
